// File: rtl/bm_rr_op_scheduler.sv
// Round-robin arbiter sharing one AND/invert unit among NREQ requesters; result tagged with winner id.
// Grant one cycle after IDLE sampling, valid OP_LAT+1 cycles after grant; requests are ignored while busy (held ones are served later).
module bm_rr_op_scheduler #(
    parameter int BITS   = 2,
    parameter int NREQ   = 4,
    parameter int ID_W   = 2,
    parameter int OP_LAT = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_in,
    input  logic [NREQ*BITS-1:0] a_in,
    input  logic [NREQ*BITS-1:0] b_in,
    input  logic [NREQ-1:0]      op_in,
    output logic [NREQ-1:0]      gnt_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic [BITS-1:0]      result_out,
    output logic [ID_W-1:0]      id_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic            op_q, op_d;
    logic [BITS-1:0] res_q, res_d;
    logic [ID_W-1:0] rid_q, rid_d;

    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr_q + ID_W'(i);
            if (req_in[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        rid_d   = rid_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_GRANT;
                    id_d    = win_id;
                    a_d     = a_in[win_id*BITS +: BITS];
                    b_d     = b_in[win_id*BITS +: BITS];
                    op_d    = op_in[win_id];
                    cnt_d   = 4'(OP_LAT);
                end
            end
            S_GRANT: state_d = S_BUSY;
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // Result registers load on entry to DONE so they are visible with valid_out.
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    res_d   = op_q ? ~a_q : (a_q & b_q);
                    rid_d   = id_q;
                end
            end
            S_DONE: begin
                ptr_d   = id_q + ID_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            rid_q   <= rid_d;
        end
    end

    always_comb begin
        gnt_out = '0;
        if (state_q == S_GRANT) begin
            gnt_out[id_q] = 1'b1;
        end
    end

    assign busy_out   = (state_q != S_IDLE);
    assign valid_out  = (state_q == S_DONE);
    assign result_out = res_q;
    assign id_out     = rid_q;

endmodule

// File: tb/tb_bm_rr_op_scheduler.sv
// Vector table plus hand sequences; expected results are queued at grant and checked when valid_out fires.
module tb_bm_rr_op_scheduler;
    localparam int BITS   = 2;
    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int OP_LAT = 2;

    logic                 clock;
    logic                 reset_n;
    logic [NREQ-1:0]      req_in;
    logic [NREQ*BITS-1:0] a_in;
    logic [NREQ*BITS-1:0] b_in;
    logic [NREQ-1:0]      op_in;
    logic [NREQ-1:0]      gnt_out;
    logic                 busy_out;
    logic                 valid_out;
    logic [BITS-1:0]      result_out;
    logic [ID_W-1:0]      id_out;

    bm_rr_op_scheduler #(.BITS(BITS), .NREQ(NREQ), .ID_W(ID_W), .OP_LAT(OP_LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_in     (req_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_in      (op_in),
        .gnt_out    (gnt_out),
        .busy_out   (busy_out),
        .valid_out  (valid_out),
        .result_out (result_out),
        .id_out     (id_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic       keep;   // leave req_in as left by the previous grant
        logic       scr;    // scramble operands while BUSY
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [3:0] gnt;
        logic [1:0] res;
        logic [1:0] id;
    } vec_t;

    typedef struct {
        logic [1:0]  res;
        logic [1:0]  id;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[15];
    int unsigned cycle;
    int unsigned last_gnt;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // Advance one clock and act as the output monitor at the following negedge.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        @(negedge clock);
        cycle++;
        if (valid_out) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'd0, valid_out}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", {30'd0, result_out}, {30'd0, e.res});
                chk("id", {30'd0, id_out}, {30'd0, e.id});
                chk("latency", cycle, e.cyc);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        if (!v.keep) req_in = v.req;
        a_in  = v.a;
        b_in  = v.b;
        op_in = v.op;
        tick();
        chk("gnt", {28'd0, gnt_out}, {28'd0, v.gnt});
        chk("busy_grant", {31'd0, busy_out}, 32'd1);
        if (v.keep) chk("gnt_gap", cycle - last_gnt, OP_LAT + 3);
        last_gnt = cycle;
        sb.push_back('{v.res, v.id, cycle + OP_LAT + 1});
        req_in = req_in & ~gnt_out;
        for (int i = 0; i < OP_LAT + 1; i++) begin
            tick();
            if (i == 0) begin
                chk("gnt_busy", {28'd0, gnt_out}, 32'd0);
                if (v.scr) begin
                    a_in = ~a_in;
                    b_in = ~b_in;
                end
            end
        end
        chk("sb_drain", sb.size(), 32'd0);
        tick();
        chk("idle_after_done", {31'd0, busy_out}, 32'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cycle    = 0;
        last_gnt = 0;
        reset_n  = 1'b0;
        req_in   = '0;
        a_in     = '0;
        b_in     = '0;
        op_in    = '0;

        //            req      kp scr a            b            op       gnt      res    id
        vecs[0]  = '{4'b1111, 0, 0, 8'b11_10_01_00, 8'b11_11_11_11, 4'b0000, 4'b0001, 2'b00, 2'd0};
        vecs[1]  = '{4'b1111, 1, 0, 8'b11_10_01_00, 8'b11_11_11_11, 4'b0000, 4'b0010, 2'b01, 2'd1};
        vecs[2]  = '{4'b1111, 1, 0, 8'b11_10_01_00, 8'b11_11_11_11, 4'b0000, 4'b0100, 2'b10, 2'd2};
        vecs[3]  = '{4'b1111, 1, 0, 8'b11_10_01_00, 8'b11_11_11_11, 4'b0000, 4'b1000, 2'b11, 2'd3};
        vecs[4]  = '{4'b0001, 0, 0, 8'b00_00_00_01, 8'b00_00_00_11, 4'b0000, 4'b0001, 2'b01, 2'd0};
        vecs[5]  = '{4'b0100, 0, 0, 8'b00_10_00_00, 8'b00_00_00_00, 4'b0100, 4'b0100, 2'b01, 2'd2};
        vecs[6]  = '{4'b0100, 0, 0, 8'b00_00_00_00, 8'b00_00_00_00, 4'b0100, 4'b0100, 2'b11, 2'd2};
        vecs[7]  = '{4'b0100, 0, 0, 8'b00_01_00_00, 8'b00_00_00_00, 4'b0100, 4'b0100, 2'b10, 2'd2};
        vecs[8]  = '{4'b0100, 0, 0, 8'b00_11_00_00, 8'b00_00_00_00, 4'b0100, 4'b0100, 2'b00, 2'd2};
        vecs[9]  = '{4'b1000, 0, 0, 8'b01_00_00_00, 8'b11_00_00_00, 4'b0000, 4'b1000, 2'b01, 2'd3};
        vecs[10] = '{4'b1001, 0, 0, 8'b10_00_00_11, 8'b11_00_00_01, 4'b0000, 4'b0001, 2'b01, 2'd0};
        vecs[11] = '{4'b1001, 1, 0, 8'b10_00_00_11, 8'b11_00_00_01, 4'b0000, 4'b1000, 2'b10, 2'd3};
        vecs[12] = '{4'b0010, 0, 1, 8'b00_00_10_00, 8'b00_00_11_00, 4'b0000, 4'b0010, 2'b10, 2'd1};
        vecs[13] = '{4'b0011, 0, 0, 8'b00_00_11_01, 8'b00_00_01_11, 4'b0010, 4'b0001, 2'b01, 2'd0};
        vecs[14] = '{4'b0011, 1, 0, 8'b00_00_11_01, 8'b00_00_01_11, 4'b0010, 4'b0010, 2'b00, 2'd1};

        #1;
        chk("rst_gnt", {28'd0, gnt_out}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_result", {30'd0, result_out}, 32'd0);
        chk("rst_id", {30'd0, id_out}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Request raised while busy, then dropped before IDLE sampling: never granted.
        req_in = 4'b0100;
        a_in   = 8'b00_11_00_00;
        b_in   = 8'b00_10_00_00;
        op_in  = 4'b0000;
        tick();
        chk("drop_gnt", {28'd0, gnt_out}, 32'b0100);
        sb.push_back('{2'b10, 2'd2, cycle + OP_LAT + 1});
        req_in = 4'b0001;
        repeat (OP_LAT + 1) tick();
        req_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drop_no_busy", {31'd0, busy_out}, 32'd0);
        end
        chk("drop_drain", sb.size(), 32'd0);

        // Reset mid-BUSY: outputs clear at once and the in-flight op never completes.
        req_in = 4'b1000;
        a_in   = 8'b11_00_00_00;
        b_in   = 8'b11_00_00_00;
        tick();
        req_in = 4'b0000;
        tick();
        chk("pre_rst_busy", {31'd0, busy_out}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy_out}, 32'd0);
        chk("mid_rst_gnt", {28'd0, gnt_out}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("mid_rst_result", {30'd0, result_out}, 32'd0);
        chk("mid_rst_id", {30'd0, id_out}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < OP_LAT + 4; i++) begin
            tick();
            chk("post_rst_idle", {31'd0, busy_out}, 32'd0);
        end

        // Pointer must be back at 0: requesters 1 and 2 pending -> 1 wins.
        run_vec('{4'b0110, 1'b0, 1'b0, 8'b00_10_01_00, 8'b00_11_01_00, 4'b0000, 4'b0010, 2'b01, 2'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
